// File: rtl/rv32_instr_encoder.sv
// RV32 instruction encoder: packs format/opcode/register/funct/immediate fields
// into a 32-bit instruction word and flags immediates that are out of range or
// misaligned for the chosen format. Encoded words are queued in a DEPTH-entry
// FIFO with valid/ready handshakes on both sides.
//
// instr_type encoding: 1=I, 2=S, 3=B, 4=U, 5=J; any other value is R-format.
//
// Optional feature: define RV32_ENC_STATS_EN to add the enc_count/err_count
// saturating statistics outputs.
module rv32_instr_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  instr_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
`ifdef RV32_ENC_STATS_EN
  ,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      enc_word;
  logic             enc_err;

  logic [31:0]      instr_mem [DEPTH];
  logic             err_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;

  // Sign-extension checks: a field of width N holds imm only if the bits above
  // it are a copy of its MSB.
  logic sext_ok_12;
  logic sext_ok_13;
  logic sext_ok_21;

  assign sext_ok_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext_ok_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext_ok_21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Field packing and range/alignment check for the requested format.
  always_comb begin
    enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
    enc_err  = 1'b0;
    unique case (instr_type)
      TYPE_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = ~sext_ok_12;
      end
      TYPE_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = ~sext_ok_12;
      end
      TYPE_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = ~sext_ok_13 | imm[0];
      end
      TYPE_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      TYPE_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = ~sext_ok_21 | imm[0];
      end
      default: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
    endcase
  end

  // in_ready depends only on the registered count, so out_ready never reaches it.
  assign in_ready  = (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);

  // flush drops any handshake that happens in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head of the FIFO; forced to zero while empty so idle outputs are quiet.
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_err   = out_valid ? err_mem[rd_ptr_q]   : 1'b0;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= enc_word;
      err_mem[wr_ptr_q]   <= enc_err;
    end
  end

`ifdef RV32_ENC_STATS_EN
  logic [15:0] enc_count_q;
  logic [15:0] err_count_q;

  // Saturating counters of accepted requests; flush leaves them alone and a
  // request dropped by flush is not counted as accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else if (push) begin
      if (enc_count_q != 16'hFFFF) begin
        enc_count_q <= enc_count_q + 16'd1;
      end
      if (enc_err && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
Inverse of the execute-stage immediate decoder. Takes an instruction format (instr_type_t) plus opcode, register, funct and 32-bit immediate fields, and packs them into a 32-bit RV32 instruction word. Range and alignment checks are applied to the immediate, and results are buffered in a small output FIFO with valid/ready handshakes on both sides. Used by the debug program buffer and self-test instruction injectors ahead of the fetch stage.

Parameters:
DEPTH, 2, output FIFO entries; legal range 1..8.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents
in_valid  in  1  request valid
in_ready  out  1  request can be accepted
instr_type  in  instr_type_t  target format (I/S/B/U/J; any other value means R-format)
opcode  in  7  opcode field
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R-format only)
imm  in  32  full immediate value in decoder convention
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction
out_err  out  1  immediate out of range or misaligned for this entry

Behaviour:
- Reset (rstn=0, asynchronous): FIFO empty, count=0, out_valid=0, out_instr=0, out_err=0, in_ready=1.
- Accept: a request is taken when in_valid && in_ready. It is encoded combinationally and written to the FIFO tail in the same edge.
- Latency: out_valid rises the cycle after acceptance when the FIFO was empty. There is no bypass path.
- in_ready = (count < DEPTH). It is registered state only, with no combinational path from out_ready.
- Pop: when out_valid && out_ready. out_instr and out_err always reflect the FIFO head and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged and ordering is preserved. When full, the push is blocked (in_ready=0) even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count is wide enough to hold DEPTH.
- flush: count=0, pointers=0, out_valid=0 next cycle. It has priority over a simultaneous push or pop (both are dropped).
- Bit packing (bits MSB..LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Error rules (the err bit is stored per entry):
  - I and S: err if imm[31:11] is not all equal.
  - B: err if imm[31:12] is not all equal, or if imm[0]=1.
  - J: err if imm[31:20] is not all equal, or if imm[0]=1.
  - U: err if imm[11:0] != 0.
  - R: never err; imm is ignored.
- On error, the word is still emitted with the truncated fields as packed above and out_err=1. The pipeline never stalls on error.
- Invariant: for any non-error entry, decoding out_instr under instr_type returns exactly imm.

Optional Feature:
Macro RV32_ENC_STATS_EN.
- Defined: adds output ports enc_count[15:0] and err_count[15:0]. They count accepted requests and accepted requests with err=1. Both saturate at 0xFFFF, reset to 0 on rstn, and are unaffected by flush.
- Undefined: the ports and counters are absent. There is no other behavioural difference.

Test Plan:
- I, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, err=0, out_valid one cycle after accept.
- S, op=0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423, err=0. B, op=0x63, all regs 0, imm=0xFFFFFFFC -> 0xFE000EE3, err=0.
- U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7, err=0. U with imm=0x12345001 -> err=1.
- Errors: I with imm=0x00000800 -> err=1. J with imm=3 -> err=1. Both still emitted in order, and the following legal request has err=0.
- Backpressure, DEPTH=2: hold out_ready=0 and push 2 -> in_ready=0, third request held. Then raise out_ready -> words pop in order and in_ready=1 the cycle after the first pop. Simultaneous push and pop at count=1 -> count stays 1.
- Assert rstn=0 with 2 entries queued -> out_valid=0 immediately. After release, in_ready=1 and FIFO empty. flush with push in the same cycle -> FIFO empty next cycle. With RV32_ENC_STATS_EN defined, check counter values after this sequence.
